// File: rtl/rom_sync_pkg.sv
// Shared definitions for the CNN accelerator memories.
// The data word width is common to every memory and to the datapath.
package rom_sync_pkg;

    localparam int DATA_BITS = 32;

    // Width of an index that covers 'depth' words, kept at least 1 bit wide.
    function automatic int index_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rom_sync.sv
// Word-addressed synchronous ROM with a registered read port, chip select and output enable.
// Contents come from hierarchical writes into Memory.
module rom_sync
    import rom_sync_pkg::*;
#(
    parameter int    ADDR_BITS = 17,
    parameter int    MEM_SIZE  = 131072,
    parameter string INIT_FILE = ""
) (
    input  logic                 CK,
    input  logic                 RST_N,
    input  logic                 CS,
    input  logic                 OE,
    input  logic [ADDR_BITS-1:0] A,
    output logic [DATA_BITS-1:0] DO
);

    localparam int IDX_BITS = index_bits(MEM_SIZE);

    // One extra bit so that MEM_SIZE == 2**ADDR_BITS is still representable.
    localparam logic [ADDR_BITS:0] MEM_LIMIT = MEM_SIZE[ADDR_BITS:0];

    logic [DATA_BITS-1:0] Memory [0:MEM_SIZE-1];
    logic [DATA_BITS-1:0] latched_do;
    logic                 addr_in_range;

    assign addr_in_range = ({1'b0, A} < MEM_LIMIT);

    // Reads past the end of the array return zero rather than wrapping.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            latched_do <= '0;
        end else if (CS) begin
            if (addr_in_range) begin
                latched_do <= Memory[A[IDX_BITS-1:0]];
            end else begin
                latched_do <= '0;
            end
        end
    end

    // OE masks the output only; the latched word survives while OE is low.
    assign DO = OE ? latched_do : '0;

endmodule

// File: tb/tb_rom_sync.sv
// Scoreboard bench for rom_sync: stimulus pushes expected words, a monitor pops and compares after each edge.
// Combinational effects (OE raise, asynchronous reset) are checked directly without a clock edge.
module tb_rom_sync;

    localparam int ADDR_BITS = 7;
    localparam int MEM_SIZE  = 100;
    localparam int DATA_BITS = 32;

    typedef struct {
        logic [DATA_BITS-1:0] exp;
        string                name;
    } exp_t;

    logic                 CK;
    logic                 RST_N;
    logic                 CS;
    logic                 OE;
    logic [ADDR_BITS-1:0] A;
    logic [DATA_BITS-1:0] DO;

    exp_t exp_q [$];
    int   check_count;
    int   error_count;

    rom_sync #(
        .ADDR_BITS(ADDR_BITS),
        .MEM_SIZE (MEM_SIZE),
        .INIT_FILE("")
    ) dut (
        .CK   (CK),
        .RST_N(RST_N),
        .CS   (CS),
        .OE   (OE),
        .A    (A),
        .DO   (DO)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Drive one read request on the falling edge and queue the word DO must show after the next rising edge.
    task automatic applyStimulus(input logic cs, input logic oe, input logic [ADDR_BITS-1:0] addr,
                                 input logic [DATA_BITS-1:0] exp, input string name);
        exp_t e;
        @(negedge CK);
        CS = cs;
        OE = oe;
        A  = addr;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [DATA_BITS-1:0] exp);
        check_count++;
        if (DO !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: DO=%h expected %h", name, DO, exp);
        end
    endtask

    // Wait, with a cycle budget, until the monitor has consumed every queued expectation.
    task automatic drain();
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 10) begin
            @(posedge CK);
            #2;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always begin
        exp_t e;
        @(posedge CK);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_count++;
            if (DO !== e.exp) begin
                error_count++;
                $display("[TB] FAIL %s: DO=%h expected %h", e.name, DO, e.exp);
            end
        end
    end

    initial begin
        check_count = 0;
        error_count = 0;
        RST_N = 1'b0;
        CS    = 1'b0;
        OE    = 1'b1;
        A     = '0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            dut.Memory[i] = 32'(i);
        end

        repeat (2) @(posedge CK);
        #1;
        checkOutput("reset_state", 32'h0);
        @(negedge CK);
        RST_N = 1'b1;

        // Back-to-back sweep: each word appears one edge after its address.
        for (int i = 0; i < MEM_SIZE; i++) begin
            applyStimulus(1'b1, 1'b1, ADDR_BITS'(i), 32'(i), $sformatf("sweep_%0d", i));
        end
        drain();

        applyStimulus(1'b1, 1'b0, 7'd5, 32'h0, "oe_low");
        drain();
        @(negedge CK);
        OE = 1'b1;
        #1;
        checkOutput("oe_raise", 32'd5);

        applyStimulus(1'b1, 1'b1, 7'd7, 32'd7, "read_7");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 7'd20, 32'd7, $sformatf("cs_hold_%0d", i));
        end
        applyStimulus(1'b1, 1'b1, 7'd20, 32'd20, "cs_resume");

        applyStimulus(1'b1, 1'b1, 7'd42, 32'd42, "read_42");
        drain();
        @(negedge CK);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset", 32'h0);
        applyStimulus(1'b1, 1'b1, 7'd3, 32'h0, "reset_wins");
        drain();
        RST_N = 1'b1;
        applyStimulus(1'b1, 1'b1, 7'd3, 32'd3, "post_reset");

        applyStimulus(1'b1, 1'b1, 7'd100, 32'h0, "oor_100");
        applyStimulus(1'b1, 1'b1, 7'd50, 32'd50, "read_50");
        applyStimulus(1'b1, 1'b1, 7'd127, 32'h0, "oor_127");
        applyStimulus(1'b1, 1'b1, 7'd99, 32'd99, "last_word");
        drain();

        dut.Memory[10] = 32'hDEADBEEF;
        applyStimulus(1'b1, 1'b1, 7'd10, 32'hDEADBEEF, "hier_write");
        drain();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
